// File: rtl/cim_wr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cim_wr_seq
// Description : Write sequencer for the CIMPQC macro array. Accepts write
//               commands over valid/ready and drives bank select, one-hot
//               wordline, write data and bitline enable through a
//               SETUP / PULSE(P cycles) / HOLD sequence so the wordline is
//               only ever active with stable select and data around it.
// Revision    : 1.0 - initial release
// ============================================================================
module cim_wr_seq #(
    parameter int NBANK = 16,
    parameter int NROW  = 8,
    parameter int DW    = 64,
    parameter int PW_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(NBANK)-1:0] cmd_bank,
    input  logic [$clog2(NROW)-1:0]  cmd_row,
    input  logic                     cmd_bcast,
    input  logic [DW-1:0]            cmd_data,
    input  logic [PW_W-1:0]          cfg_pulse,
    output logic [NBANK-1:0]         cs,
    output logic [NROW-1:0]          WA0,
    output logic [DW-1:0]            wdata,
    output logic                     wbl_en,
    output logic                     busy,
    output logic                     done
);

    localparam int c_ROW_W = $clog2(NROW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic [PW_W-1:0]     w_pulse_m1;
    logic [NBANK-1:0]    w_cs_sel;
    logic [NROW-1:0]     w_wa_sel;
    logic [PW_W-1:0]     r_cnt;
    logic [c_ROW_W-1:0]  r_row;
    logic [NBANK-1:0]    r_cs;
    logic [NROW-1:0]     r_wa0;
    logic [DW-1:0]       r_wdata;
    logic                r_wbl_en;
    logic                r_done;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    // A zero pulse configuration behaves as a single-cycle pulse.
    assign w_pulse_m1 = (cfg_pulse == '0) ? '0 : (cfg_pulse - PW_W'(1));
    assign w_cs_sel   = cmd_bcast ? '1 : (NBANK'(1) << cmd_bank);
    assign w_wa_sel   = NROW'(1) << r_row;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; PULSE exits once the down-counter has run out.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: w_next = S_PULSE;
            S_PULSE: if (r_cnt == '0) w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Latch row and pulse length on accept; count the pulse down in PULSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_cnt <= w_pulse_m1;
            r_row <= cmd_row;
        end else if ((r_state == S_PULSE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - PW_W'(1);
        end
    end

    // Output flops are loaded from the upcoming state so every output
    // changes together with the state and comes straight from a flop.
    // SETUP is only entered on accept, so it samples the command inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs     <= '0;
            r_wa0    <= '0;
            r_wdata  <= '0;
            r_wbl_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_HOLD);
            case (w_next)
                S_SETUP: begin
                    r_cs     <= w_cs_sel;
                    r_wdata  <= cmd_data;
                    r_wbl_en <= 1'b1;
                    r_wa0    <= '0;
                end
                S_PULSE: r_wa0 <= w_wa_sel;
                S_HOLD:  r_wa0 <= '0;
                default: begin
                    r_cs     <= '0;
                    r_wa0    <= '0;
                    r_wdata  <= '0;
                    r_wbl_en <= 1'b0;
                end
            endcase
        end
    end

    assign cs        = r_cs;
    assign WA0       = r_wa0;
    assign wdata     = r_wdata;
    assign wbl_en    = r_wbl_en;
    assign done      = r_done;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/cim_wr_seq.md
# cim_wr_seq

Write sequencer feeding the chip-select word-address driver stage of the CIMPQC macro array. It accepts write commands over a valid/ready handshake and drives the downstream inputs: `cs[15:0]` (one-hot bank select, or all banks for broadcast) and `WA0[7:0]` (one-hot wordline), plus the write data and bitline-drive enable. A fixed setup/pulse/hold sequence guarantees that no wordline is active unless `cs` and data were stable for at least one cycle before and stay stable one cycle after.

## Interface

Parameters:
- `NBANK`, 16: number of banks; sets the `cs` width.
- `NROW`, 8: wordlines per bank; sets the `WA0` width.
- `DW`, 64: write data width.
- `PW_W`, 4: width of the pulse-length configuration.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `cmd_valid`, in, 1: write command present.
- `cmd_ready`, out, 1: sequencer can accept a command; high exactly when state is IDLE.
- `cmd_bank`, in, 4: target bank index 0..15.
- `cmd_row`, in, 3: target wordline index 0..7.
- `cmd_bcast`, in, 1: when 1, write to all banks and ignore `cmd_bank`.
- `cmd_data`, in, DW: write data.
- `cfg_pulse`, in, PW_W: wordline pulse length in cycles; 0 is treated as 1.
- `cs`, out, NBANK: bank select to the driver stage; registered.
- `WA0`, out, NROW: one-hot wordline to the driver stage; registered.
- `wdata`, out, DW: write data to the bitline drivers; registered.
- `wbl_en`, out, 1: bitline drive enable; registered.
- `busy`, out, 1: high when state is not IDLE.
- `done`, out, 1: one-cycle pulse, high in the first IDLE cycle after HOLD.

## Operation

- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - `cs`, `WA0`, `wdata` and `wbl_en` are 0.
  - On `cmd_valid & cmd_ready`, latch bank, row, bcast, data and P = max(`cfg_pulse`, 1), then go to SETUP.
- SETUP, 1 cycle:
  - `cs` = one-hot(`cmd_bank`), or all ones if bcast.
  - `wdata` = latched data, `wbl_en` = 1, `WA0` = 0.
  - Go to PULSE.
- PULSE, P cycles:
  - `cs`, `wdata` and `wbl_en` unchanged.
  - `WA0` = one-hot(`cmd_row`).
  - A down-counter loaded with P-1 moves to HOLD when it reaches 0.
- HOLD, 1 cycle:
  - `WA0` = 0; `cs`, `wdata` and `wbl_en` still held.
  - Go to IDLE and assert `done` for that first IDLE cycle.
- `cmd_*` and `cfg_pulse` changes while busy have no effect; latched values are used.
- Back-to-back: a command presented during the `done` cycle is accepted that cycle. Its SETUP follows immediately, so `cs` drops to 0 for exactly that one IDLE cycle.
- Invariants:
  - `WA0` is either 0 or one-hot.
  - `WA0` ≠ 0 implies `cs` ≠ 0 and `wbl_en` = 1.
  - `cs` never changes while `WA0` ≠ 0.
- Reset while `rst_n` is low, at any state:
  - State goes to IDLE immediately (async).
  - All outputs go to 0 except `cmd_ready` = 1.
  - `done` is not generated for an aborted command, and no command is accepted while `rst_n` is low.

## Timing

- Reset values: `cs` = 0, `WA0` = 0, `wdata` = 0, `wbl_en` = 0, `busy` = 0, `done` = 0, `cmd_ready` = 1.
- Let cycle 0 be the accept edge. Then:
  - SETUP outputs are visible in cycle 1.
  - `WA0` is active in cycles 2..P+1.
  - HOLD is cycle P+2.
  - `done` = 1 and `cmd_ready` = 1 in cycle P+3.
- Throughput is one command per P+3 cycles.
- `busy` = 1 in cycles 1..P+2.
- All outputs come straight from flops, so downstream combinational gating sees glitch-free signals.

## Test plan

- Reset, then `cmd_bank`=5, `cmd_row`=2, `cfg_pulse`=3, data=0xA5A5…:
  - `cs`=0x0020 in cycles 1–5.
  - `WA0`=0x04 in cycles 2–4 only.
  - `done` in cycle 6.
- Broadcast with `cmd_row`=7, `cfg_pulse`=0: `cs`=0xFFFF, `WA0`=0x80 for exactly 1 cycle, `done` in cycle 4.
- Back-to-back commands to bank 0 then bank 15 with `cfg_pulse`=1:
  - Second is accepted in the `done` cycle.
  - `cs` shows 0x0001, then 0 for one cycle, then 0x8000.
- Change `cmd_bank`, `cmd_row` and `cfg_pulse` mid-PULSE: outputs keep the latched values and pulse length.
- Assert `rst_n` low mid-PULSE: all outputs are 0 immediately and there is no `done`. After release, a new command runs normally.
- Random commands (≥1000) with an invariant checker for one-hot `WA0`, `cs` stability and the `wbl_en` cover rules, plus a scoreboard of bank/row/data per `done`.
